// File: rtl/disc_write_mem_seq_pkg.sv
// disc_write_mem_seq_pkg: shared state encoding and constants for the disc-writer program-memory sequencer.
`default_nettype none

package disc_write_mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_PRIME0 = 3'd0,
    ST_PRIME1 = 3'd1,
    ST_PRIME2 = 3'd2,
    ST_READY  = 3'd3,
    ST_HWRITE = 3'd4
  } state_e;

  localparam logic [7:0] STOP_OP          = 8'h3F;
  localparam int         CLKEN_MIN_PERIOD = 3;

endpackage

`default_nettype wire

// File: rtl/disc_write_mem_seq.sv
// disc_write_mem_seq: feeds instruction bytes from an external sync RAM to the disc writer
// with a one-byte prefetch, and gives the host load/write/read access while the writer is idle.
`default_nettype none

module disc_write_mem_seq
  import disc_write_mem_seq_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clken,
  input  logic              running,
  input  logic              maddr_inc,
  output logic [7:0]        mdat,
  input  logic              host_addr_load,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_wr,
  input  logic [7:0]        host_wdata,
  input  logic              host_rd,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic              ready,
  output logic              host_err,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2);

  state_e            state_q;
  logic              clken_d_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        mdat_q;
  logic [7:0]        nxt_q;
  logic [7:0]        host_rdata_q;
  logic [7:0]        ram_wdata_q;
  logic              host_rvalid_q;
  logic              host_err_q;
  logic              ram_we_q;

  logic host_any;
  logic host_ok;
  logic inc_req;
  logic inc_ok;

  assign host_any = host_addr_load | host_wr | host_rd;
  assign host_ok  = (state_q == ST_READY) && !running;
  assign inc_req  = clken_d_q && maddr_inc && running;
  assign inc_ok   = inc_req && (state_q == ST_READY);

  // ram_addr_q is always loaded with the address the RAM must sample during the next state,
  // so read data lands in the state that captures it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_PRIME0;
      clken_d_q     <= 1'b0;
      cur_addr_q    <= '0;
      ram_addr_q    <= '0;
      mdat_q        <= STOP_OP;
      nxt_q         <= STOP_OP;
      host_rdata_q  <= 8'h00;
      ram_wdata_q   <= 8'h00;
      host_rvalid_q <= 1'b0;
      host_err_q    <= 1'b0;
      ram_we_q      <= 1'b0;
    end else begin
      clken_d_q     <= clken;
      host_rvalid_q <= 1'b0;
      ram_we_q      <= 1'b0;
      if ((host_any && !host_ok) || (inc_req && !inc_ok)) begin
        host_err_q <= 1'b1;
      end
      case (state_q)
        ST_PRIME0: begin
          ram_addr_q <= cur_addr_q + ADDR_ONE;
          state_q    <= ST_PRIME1;
        end
        ST_PRIME1: begin
          mdat_q  <= ram_rdata;
          state_q <= ST_PRIME2;
        end
        ST_PRIME2: begin
          nxt_q      <= ram_rdata;
          ram_addr_q <= cur_addr_q + ADDR_TWO;
          state_q    <= ST_READY;
        end
        ST_READY: begin
          if (inc_ok) begin
            // RAM is already reading cur+2, which becomes the new prefetch byte
            mdat_q     <= nxt_q;
            cur_addr_q <= cur_addr_q + ADDR_ONE;
            ram_addr_q <= cur_addr_q + ADDR_TWO;
            state_q    <= ST_PRIME2;
          end else if (host_ok && host_addr_load) begin
            cur_addr_q <= host_addr;
            ram_addr_q <= host_addr;
            state_q    <= ST_PRIME0;
          end else if (host_ok && host_wr) begin
            ram_addr_q  <= cur_addr_q;
            ram_wdata_q <= host_wdata;
            ram_we_q    <= 1'b1;
            state_q     <= ST_HWRITE;
          end else if (host_ok && host_rd) begin
            host_rdata_q  <= mdat_q;
            host_rvalid_q <= 1'b1;
            cur_addr_q    <= cur_addr_q + ADDR_ONE;
            ram_addr_q    <= cur_addr_q + ADDR_ONE;
            state_q       <= ST_PRIME0;
          end
        end
        ST_HWRITE: begin
          cur_addr_q <= cur_addr_q + ADDR_ONE;
          ram_addr_q <= cur_addr_q + ADDR_ONE;
          state_q    <= ST_PRIME0;
        end
        default: state_q <= ST_PRIME0;
      endcase
    end
  end

  assign mdat        = mdat_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign ready       = (state_q == ST_READY);
  assign host_err    = host_err_q;
  assign cur_addr    = cur_addr_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;

endmodule

`default_nettype wire

// File: tb/tb_disc_write_mem_seq.sv
// tb_disc_write_mem_seq: directed scenarios against disc_write_mem_seq with a behavioural sync RAM.
`default_nettype none

module tb_disc_write_mem_seq;

  localparam int ADDR_W = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clken = 1'b0;
  logic              running = 1'b0;
  logic              maddr_inc = 1'b0;
  logic [7:0]        mdat;
  logic              host_addr_load = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic              host_wr = 1'b0;
  logic [7:0]        host_wdata = 8'h00;
  logic              host_rd = 1'b0;
  logic [7:0]        host_rdata;
  logic              host_rvalid;
  logic              ready;
  logic              host_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata = 8'h00;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              bd_en = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_data = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Read-first synchronous RAM, with a backdoor port so preloading stays in this one process
  always @(posedge clock) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  disc_write_mem_seq #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .clken(clken), .running(running),
    .maddr_inc(maddr_inc), .mdat(mdat),
    .host_addr_load(host_addr_load), .host_addr(host_addr),
    .host_wr(host_wr), .host_wdata(host_wdata), .host_rd(host_rd),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .ready(ready),
    .host_err(host_err), .cur_addr(cur_addr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_en = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready: ready=%b after %0d clocks, required 1", tag, ready, n);
    end
  endtask

  task automatic host_load(input logic [ADDR_W-1:0] a);
    host_addr_load = 1'b1; host_addr = a;
    tick();
    host_addr_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    poke(15'h0000, 8'h02);
    poke(15'h0001, 8'h02);
    poke(15'h0002, 8'h3F);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    checks++; if (mdat !== 8'h3F) begin errors++; $display("FAIL rst_mdat: got %h want 3f", mdat); end
    checks++; if (cur_addr !== 15'h0) begin errors++; $display("FAIL rst_cur_addr: got %h want 0", cur_addr); end
    checks++; if (host_err !== 1'b0) begin errors++; $display("FAIL rst_host_err: got %b want 0", host_err); end
    checks++; if (host_rvalid !== 1'b0 || host_rdata !== 8'h00) begin
      errors++; $display("FAIL rst_host_read: rvalid=%b rdata=%h want 0/00", host_rvalid, host_rdata);
    end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ready !== (i == 3)) begin
        errors++; $display("FAIL rst_ready_clk%0d: got %b want %b", i, ready, (i == 3));
      end
    end
    checks++; if (mdat !== 8'h02) begin errors++; $display("FAIL rst_mdat_primed: got %h want 02", mdat); end
  endtask

  task automatic test_host_rw();
    host_load(15'h0010);
    wait_ready("hrw_load1");
    host_wr = 1'b1; host_wdata = 8'hA5;
    tick();
    host_wr = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 15'h0010 || ram_wdata !== 8'hA5) begin
      errors++; $display("FAIL hrw_ram_write: we=%b addr=%h data=%h want 1/0010/a5", ram_we, ram_addr, ram_wdata);
    end
    tick();
    checks++; if (ram_we !== 1'b0 || cur_addr !== 15'h0011) begin
      errors++; $display("FAIL hrw_after_write: we=%b cur=%h want 0/0011", ram_we, cur_addr);
    end
    wait_ready("hrw_wr");
    host_load(15'h0010);
    wait_ready("hrw_load2");
    checks++; if (mdat !== 8'hA5) begin errors++; $display("FAIL hrw_mdat: got %h want a5", mdat); end
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 8'hA5 || cur_addr !== 15'h0011) begin
      errors++; $display("FAIL hrw_read: rvalid=%b rdata=%h cur=%h want 1/a5/0011", host_rvalid, host_rdata, cur_addr);
    end
    tick();
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hrw_rvalid_pulse: got %b want 0", host_rvalid); end
    wait_ready("hrw_rd");
  endtask

  task automatic test_increment();
    for (int i = 0; i < 5; i++) poke(ADDR_W'(32 + i), 8'(8'h80 + i));
    host_load(15'h0020);
    wait_ready("inc_load");
    checks++; if (mdat !== 8'h80) begin errors++; $display("FAIL inc_mdat0: got %h want 80", mdat); end
    running = 1'b1; maddr_inc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clken = 1'b1;
      tick();
      clken = 1'b0;
      tick();
      checks++;
      if (mdat !== 8'(8'h81 + k) || cur_addr !== ADDR_W'(33 + k) || ready !== 1'b0) begin
        errors++;
        $display("FAIL inc_step%0d: mdat=%h cur=%h ready=%b want %h/%h/0", k, mdat, cur_addr, ready,
                 8'(8'h81 + k), ADDR_W'(33 + k));
      end
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL inc_ready%0d: got %b want 1", k, ready); end
    end
    maddr_inc = 1'b0; running = 1'b0;
    tick();
    checks++; if (host_err !== 1'b0 || mdat !== 8'h84) begin
      errors++; $display("FAIL inc_final: err=%b mdat=%h want 0/84", host_err, mdat);
    end
  endtask

  task automatic test_wrap();
    poke(15'h7FFF, 8'h11);
    poke(15'h0000, 8'h22);
    poke(15'h0001, 8'h33);
    host_load(15'h7FFF);
    wait_ready("wrap_load");
    checks++; if (mdat !== 8'h11 || cur_addr !== 15'h7FFF) begin
      errors++; $display("FAIL wrap_start: mdat=%h cur=%h want 11/7fff", mdat, cur_addr);
    end
    running = 1'b1; maddr_inc = 1'b1;
    clken = 1'b1; tick(); clken = 1'b0; tick();
    checks++; if (mdat !== 8'h22 || cur_addr !== 15'h0000) begin
      errors++; $display("FAIL wrap_inc1: mdat=%h cur=%h want 22/0000", mdat, cur_addr);
    end
    tick();
    clken = 1'b1; tick(); clken = 1'b0; tick();
    checks++; if (mdat !== 8'h33 || cur_addr !== 15'h0001) begin
      errors++; $display("FAIL wrap_inc2: mdat=%h cur=%h want 33/0001", mdat, cur_addr);
    end
    maddr_inc = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b want 1", ready); end
  endtask

  task automatic test_error();
    host_wr = 1'b1; host_wdata = 8'h5A;
    tick();
    host_wr = 1'b0;
    checks++; if (host_err !== 1'b1 || ready !== 1'b1 || ram_we !== 1'b0 || cur_addr !== 15'h0001) begin
      errors++; $display("FAIL err_set: err=%b ready=%b we=%b cur=%h want 1/1/0/0001", host_err, ready, ram_we, cur_addr);
    end
    running = 1'b0;
    tick(); tick();
    checks++; if (host_err !== 1'b1 || mem[1] !== 8'h33 || mdat !== 8'h33) begin
      errors++; $display("FAIL err_sticky: err=%b mem1=%h mdat=%h want 1/33/33", host_err, mem[1], mdat);
    end
  endtask

  task automatic test_reset_hwrite();
    host_wr = 1'b1; host_wdata = 8'hC3;
    tick();
    host_wr = 1'b0;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rhw_we_before: got %b want 1", ram_we); end
    reset = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0 || mdat !== 8'h3F || ready !== 1'b0 || host_err !== 1'b0 || cur_addr !== 15'h0) begin
      errors++; $display("FAIL rhw_reset: we=%b mdat=%h ready=%b err=%b cur=%h want 0/3f/0/0/0000",
                         ram_we, mdat, ready, host_err, cur_addr);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ready !== (i == 3)) begin
        errors++; $display("FAIL rhw_ready_clk%0d: got %b want %b", i, ready, (i == 3));
      end
    end
    checks++; if (mdat !== 8'h22) begin errors++; $display("FAIL rhw_mdat: got %h want 22", mdat); end
  endtask

  initial begin
    #1;
    test_reset();
    test_host_rw();
    test_increment();
    test_wrap();
    test_error();
    test_reset_hwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disc_write_mem_seq.md
DISC_WRITE_MEM_SEQ -- requirements
Module: disc_write_mem_seq

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the program-memory address width; depth is 2^ADDR_W bytes.
REQ-002 clock  in  1  master clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 clken  in  1  disc-writer clock enable; period SHALL be at least 3 clocks.
REQ-005 running  in  1  disc-writer running flag.
REQ-006 maddr_inc  in  1  disc-writer address-increment request, registered on clken.
REQ-007 mdat  out  8  instruction byte at the current address, to the disc writer.
REQ-008 host_addr_load  in  1  one-clock strobe that loads the address from host_addr.
REQ-009 host_addr  in  ADDR_W  host load address.
REQ-010 host_wr  in  1  one-clock strobe that writes host_wdata at the current address, then increments it.
REQ-011 host_wdata  in  8  host write byte.
REQ-012 host_rd  in  1  one-clock strobe that returns the byte at the current address, then increments it.
REQ-013 host_rdata  out  8  host read byte, valid while host_rvalid is high.
REQ-014 host_rvalid  out  1  one-clock pulse marking host_rdata valid.
REQ-015 ready  out  1  high when mdat and the prefetch register are both primed.
REQ-016 host_err  out  1  sticky flag, set by any host strobe accepted while running=1 or ready=0.
REQ-017 cur_addr  out  ADDR_W  current address.
REQ-018 ram_addr/ram_wdata/ram_we  out  ADDR_W/8/1  single-port synchronous RAM; ram_rdata  in  8  valid one clock after ram_addr.

Function
REQ-019 The FSM SHALL have the states PRIME0, PRIME1, PRIME2, READY, HWRITE.
- PRIME0: drive ram_addr=cur_addr.
- PRIME1: capture mdat<=ram_rdata; drive cur_addr+1.
- PRIME2: capture nxt<=ram_rdata; go to READY.
REQ-020 ready SHALL be high only in READY.
REQ-021 In READY with running=0, host strobes SHALL have this priority: host_addr_load > host_wr > host_rd.
- host_addr_load: cur_addr<=host_addr, go to PRIME0.
- host_wr: go to HWRITE.
- host_rd: host_rdata<=mdat, host_rvalid pulses on the next clock, cur_addr increments, go to PRIME0.
REQ-022 HWRITE SHALL assert ram_we for exactly one clock at cur_addr with host_wdata, increment cur_addr, then go to PRIME0.
REQ-023 Host strobes outside the accepting condition SHALL be ignored (no state change) and SHALL set host_err.
REQ-024 An increment SHALL be accepted when clken_d (clken delayed one clock) =1, maddr_inc=1, running=1 and the state is READY.
REQ-025 On an accepted increment, on that same clock edge: mdat<=nxt; cur_addr<=cur_addr+1; ram_addr<=cur_addr+2; ready falls for one clock; nxt is captured on the next edge; READY is regained.
REQ-026 The writer-visible latency from an accepted increment to the new mdat SHALL be 1 clock, and SHALL always be complete before the next clken edge.
REQ-027 All address arithmetic SHALL be modulo 2^ADDR_W; 2^ADDR_W-1 SHALL wrap to 0, including within prefetch.
REQ-028 maddr_inc while not READY SHALL be dropped and SHALL set host_err; this is a clken-period violation.
REQ-029 running falling SHALL NOT disturb the address or mdat; host access resumes from the current address.
REQ-030 host_err SHALL clear only on reset.

Reset
REQ-031 Reset SHALL force state=PRIME0, cur_addr=0, mdat=8'h3F (STOP), nxt=8'h3F, host_rdata=0, host_rvalid=0, host_err=0, ram_we=0, clken_d=0.
REQ-032 After reset release, ready SHALL assert 3 clocks later with mdat=RAM[0].
REQ-033 Reset mid-HWRITE SHALL abort the write (ram_we low immediately); RAM contents at that address are undefined.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the STOP opcode constant 8'h3F, and CLKEN_MIN_PERIOD=3.
REQ-035 No sub-module is required; the RAM SHALL be external, instantiated by the parent next to the disc writer.

Verification
REQ-036 Reset, then load RAM[0..2]={02,02,3F} -> ready after 3 clocks, mdat=02.
REQ-037 host_addr_load 0x0010, host_wr 0xA5, host_addr_load 0x0010, host_rd -> host_rdata=A5, cur_addr=0x0011.
REQ-038 running=1 with clken every 3 clocks and maddr_inc held high for 4 clken periods over RAM {80,81,82,83,84} -> mdat steps 81, 82, 83, 84, one step per clken, with no repeats.
REQ-039 cur_addr=0x7FFF, RAM[7FFF]=11, RAM[0]=22, RAM[1]=33; one accepted increment -> cur_addr=0, mdat=22, nxt=33.
REQ-040 host_wr while running=1 -> RAM unchanged, host_err=1 and stays 1 after running falls.
REQ-041 Assert reset during HWRITE -> ram_we=0 within the same cycle, mdat=3F, ready returns 3 clocks after release.
